// File: rtl/posit_dot_seq.sv
// Sequential posit<N,2> dot product: one operand pair per cycle through a
// two-stage pipe into a 16*N-bit quire, with a valid/ready result handshake.

module posit_mac #(
  parameter int N  = 8,
  parameter int QW = 16 * N
) (
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [QW-1:0] c,
  output logic [QW-1:0] r
);
  localparam int PW = 2 * N - 4;    // product of two (N-2)-bit significands
  localparam int FB = 2 * (N - 3);  // fraction bits carried by the product
  localparam int QF = 8 * N - 16;   // quire fraction bits (minpos^2 is the LSB)
  localparam int EW = QW + FB;
  localparam logic [QW-1:0] NARQ = {1'b1, {(QW-1){1'b0}}};

  typedef struct packed {
    logic              nar;
    logic              zero;
    logic              sign;
    logic signed [15:0] scale;
    logic [N-3:0]      mant;
  } dec_t;

  function automatic dec_t decode(input logic [N-1:0] p);
    dec_t         d;
    logic [N-2:0] mag;
    logic [N-2:0] rem;
    logic         r0;
    logic         run_on;
    int           run;
    int           k;
    d      = '0;
    d.sign = p[N-1];
    d.nar  = p[N-1] & ~|p[N-2:0];
    d.zero = ~|p;
    mag    = p[N-1] ? (~p[N-2:0] + 1'b1) : p[N-2:0];
    r0     = mag[N-2];
    run    = 0;
    run_on = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run_on && (mag[i] == r0)) run = run + 1;
      else                          run_on = 1'b0;
    end
    // Drop regime run plus its terminator; es then fraction sit left-aligned.
    rem     = mag << (run + 1);
    k       = r0 ? (run - 1) : -run;
    d.scale = 16'(4 * k + int'(rem[N-2:N-3]));
    d.mant  = {1'b1, rem[N-4:0]};
    return d;
  endfunction

  dec_t           da, db;
  logic [PW-1:0]  prod;
  logic [EW-1:0]  ext;
  logic [QW-1:0]  addend;
  int             sh;

  always_comb begin
    da     = decode(a);
    db     = decode(b);
    prod   = PW'(da.mant) * PW'(db.mant);
    sh     = int'($signed(da.scale)) + int'($signed(db.scale)) + QF;
    ext    = EW'(prod) << sh;
    addend = QW'(ext >> FB);
    if ((c == NARQ) || da.nar || db.nar) r = NARQ;
    else if (da.zero || db.zero)         r = c;
    else if (da.sign ^ db.sign)          r = c - addend;
    else                                 r = c + addend;
  end
endmodule

module posit_dot_seq #(
  parameter int N     = 8,
  parameter int LEN_W = 8,
  parameter int QW    = 16 * N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             acc_en,
  input  logic [QW-1:0]    c_init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    quire,
  output logic             nar,
  output logic             busy
);
  localparam logic [QW-1:0] NARQ = {1'b1, {(QW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t           state, next_state;
  logic [LEN_W-1:0] cnt;
  logic [N-1:0]     stage_a, stage_b;
  logic             stage_v;
  logic             beat;
  logic [QW-1:0]    mac_r;

  posit_mac #(.N(N), .QW(QW)) u_mac (
    .a (stage_a),
    .b (stage_b),
    .c (quire),
    .r (mac_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    beat       = 1'b0;
    case (state)
      IDLE:  if (start) next_state = (len == '0) ? DONE : ACC;
      ACC: begin
        in_ready = 1'b1;
        beat     = in_valid;
        if (beat && (cnt == LEN_W'(1))) next_state = DRAIN;
      end
      DRAIN: next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Stage 1 captures the pair; stage 2 folds it into the quire next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      stage_a <= '0;
      stage_b <= '0;
      stage_v <= 1'b0;
      quire   <= '0;
    end else begin
      stage_v <= beat;
      if (beat) begin
        stage_a <= a;
        stage_b <= b;
        cnt     <= cnt - 1'b1;
      end
      if ((state == IDLE) && start) begin
        cnt   <= len;
        quire <= acc_en ? c_init : '0;
      end else if (stage_v) begin
        quire <= mac_r;
      end
    end
  end

  assign nar  = (quire == NARQ);
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_posit_dot_seq.sv
// Directed bench for posit_dot_seq (posit<8,2>, 128-bit quire, LSB = 2^-48).

module tb_posit_dot_seq;
  localparam int N = 8;
  localparam int LEN_W = 8;
  localparam int QW = 128;
  localparam logic [QW-1:0] ONE  = 128'd1 << 48;
  localparam logic [QW-1:0] NARQ = 128'd1 << 127;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             acc_en = 1'b0;
  logic [QW-1:0]    c_init = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     a = '0, b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [QW-1:0]    quire;
  logic             nar;
  logic             busy;

  int total = 0;
  int bad = 0;
  logic [7:0] va[16];
  logic [7:0] vb[16];

  posit_dot_seq #(.N(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .acc_en(acc_en),
    .c_init(c_init), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .quire(quire), .nar(nar),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic feed(input int n, input logic ae, input logic [QW-1:0] ci,
                      input logic [31:0] gaps, output int lat, output int tot);
    tot = 0;
    @(negedge clk);
    start = 1'b1; len = LEN_W'(n); acc_en = ae; c_init = ci;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps[i % 32]) begin
        in_valid = 1'b0;
        @(negedge clk); tot++;
      end
      in_valid = 1'b1; a = va[i]; b = vb[i];
      @(negedge clk); tot++;
    end
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++; tot++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (quire !== '0)       begin bad++; $display("FAIL reset_quire got=%h want=0", quire); end
    total++; if (nar !== 1'b0)       begin bad++; $display("FAIL reset_nar got=%b want=0", nar); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, tot;
    va[0] = 8'h40; vb[0] = 8'h40; va[1] = 8'hC0; vb[1] = 8'h40;
    feed(2, 1'b0, '0, 32'h0, lat, tot);
    total++; if (lat !== 2)     begin bad++; $display("FAIL basic_latency got=%0d want=2", lat); end
    total++; if (quire !== '0)  begin bad++; $display("FAIL basic_quire got=%h want=0", quire); end
    total++; if (nar !== 1'b0)  begin bad++; $display("FAIL basic_nar got=%b want=0", nar); end
    ack();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", busy); end
  endtask

  task automatic test_zero();
    int lat, tot;
    va[0] = 8'h00; vb[0] = 8'h40;
    va[1] = 8'h00; vb[1] = 8'h7F;
    va[2] = 8'h00; vb[2] = 8'h01;
    // c_init ignored because acc_en=0
    feed(3, 1'b0, 128'hABCD, 32'b010, lat, tot);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_out_valid got=%b want=1", out_valid); end
    total++; if (quire !== '0)       begin bad++; $display("FAIL zero_quire got=%h want=0", quire); end
    total++; if (nar !== 1'b0)       begin bad++; $display("FAIL zero_nar got=%b want=0", nar); end
    ack();
  endtask

  task automatic test_nar();
    int lat, tot;
    va[0] = 8'h40; vb[0] = 8'h40;
    va[1] = 8'h80; vb[1] = 8'h40;
    va[2] = 8'h40; vb[2] = 8'h40;
    va[3] = 8'h48; vb[3] = 8'h40;
    feed(4, 1'b0, '0, 32'h0, lat, tot);
    total++; if (quire !== NARQ) begin bad++; $display("FAIL nar_quire got=%h want=%h", quire, NARQ); end
    total++; if (nar !== 1'b1)   begin bad++; $display("FAIL nar_flag got=%b want=1", nar); end
    ack();
  endtask

  task automatic test_len0();
    logic [QW-1:0] ci;
    ci = 128'h0123_4567_89AB_CDEF_0000_0000_0000_1234;
    @(negedge clk);
    start = 1'b1; len = '0; acc_en = 1'b1; c_init = ci;
    @(negedge clk);
    start = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL len0_out_valid got=%b want=1", out_valid); end
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL len0_in_ready got=%b want=0", in_ready); end
    total++; if (quire !== ci)       begin bad++; $display("FAIL len0_quire got=%h want=%h", quire, ci); end
    in_valid = 1'b1; a = 8'h40; b = 8'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || quire !== ci) begin
        bad++; $display("FAIL len0_hold cyc=%0d got=%b/%h want=1/%h", i, out_valid, quire, ci);
      end
    end
    in_valid = 1'b0;
    ack();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_idle got=%b want=0", busy); end
    repeat (2) @(negedge clk);
    total++; if (quire !== ci)  begin bad++; $display("FAIL len0_idle_hold got=%h want=%h", quire, ci); end
  endtask

  task automatic test_values();
    int lat, tot;
    logic [QW-1:0] exp_q;
    // 1 + 2 + 16 + 2.25 - 2 = 19.25 = 77 * 2^-2, plus seed 5 LSBs
    va[0] = 8'h40; vb[0] = 8'h40;
    va[1] = 8'h48; vb[1] = 8'h40;
    va[2] = 8'h50; vb[2] = 8'h50;
    va[3] = 8'h44; vb[3] = 8'h44;
    va[4] = 8'hC0; vb[4] = 8'h48;
    exp_q = (128'd77 << 46) + 128'd5;
    feed(5, 1'b1, 128'd5, 32'b10110, lat, tot);
    total++; if (lat !== 2)       begin bad++; $display("FAIL values_latency got=%0d want=2", lat); end
    total++; if (quire !== exp_q) begin bad++; $display("FAIL values_quire got=%h want=%h", quire, exp_q); end
    ack();
  endtask

  task automatic test_extremes();
    int lat, tot;
    logic [QW-1:0] exp_q;
    // minpos^2 + maxpos^2 - minpos^2 = 2^48 -> bit 96
    va[0] = 8'h01; vb[0] = 8'h01;
    va[1] = 8'h7F; vb[1] = 8'h7F;
    va[2] = 8'hFF; vb[2] = 8'h01;
    exp_q = 128'd1 << 96;
    feed(3, 1'b0, '0, 32'h0, lat, tot);
    total++; if (quire !== exp_q) begin bad++; $display("FAIL extreme_quire got=%h want=%h", quire, exp_q); end
    ack();
    va[0] = 8'h01; vb[0] = 8'h01;
    feed(1, 1'b1, '1, 32'h0, lat, tot);
    total++; if (quire !== '0 || nar !== 1'b0) begin
      bad++; $display("FAIL wrap_quire got=%h/%b want=0/0", quire, nar);
    end
    ack();
    va[0] = 8'hC0; vb[0] = 8'h40;
    exp_q = 128'd0 - ONE;
    feed(1, 1'b0, '0, 32'h0, lat, tot);
    total++; if (quire !== exp_q) begin bad++; $display("FAIL negone_quire got=%h want=%h", quire, exp_q); end
    ack();
  endtask

  task automatic test_back_to_back();
    int lat, tot;
    for (int i = 0; i < 4; i++) begin va[i] = 8'h40; vb[i] = 8'h40; end
    feed(4, 1'b0, '0, 32'h0, lat, tot);
    total++; if (tot !== 5)             begin bad++; $display("FAIL b2b_cycles got=%0d want=5", tot); end
    total++; if (quire !== (ONE << 2))  begin bad++; $display("FAIL b2b_quire got=%h want=%h", quire, ONE << 2); end
    ack();
  endtask

  task automatic test_busy_start();
    @(negedge clk);
    start = 1'b1; len = 8'd2; acc_en = 1'b0; c_init = '0;
    @(negedge clk);
    // a second start in ACC with a different seed must be ignored
    start = 1'b1; len = 8'd1; acc_en = 1'b1; c_init = 128'hDEAD;
    in_valid = 1'b1; a = 8'h40; b = 8'h40;
    @(negedge clk);
    start = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL busy_acc got=%b/%b want=1/0", in_ready, out_valid);
    end
    a = 8'h48; b = 8'h40;
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL drain_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || quire !== 3 * ONE) begin
      bad++; $display("FAIL busy_result got=%b/%h want=1/%h", out_valid, quire, 3 * ONE);
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || quire !== 3 * ONE) begin
      bad++; $display("FAIL busy_done_hold got=%b/%h want=1/%h", out_valid, quire, 3 * ONE);
    end
    start = 1'b0;
    ack();
  endtask

  task automatic test_rst_abort();
    int lat, tot;
    @(negedge clk);
    start = 1'b1; len = 8'd5; acc_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; a = 8'h40; b = 8'h40;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || quire !== '0 || nar !== 1'b0) begin
      bad++; $display("FAIL abort_outputs got=%b%b%b/%h/%b want=000/0/0", busy, in_ready, out_valid, quire, nar);
    end
    @(negedge clk);
    rst = 1'b0;
    va[0] = 8'h44; vb[0] = 8'h40;
    feed(1, 1'b0, '0, 32'h0, lat, tot);
    total++; if (lat !== 2)                   begin bad++; $display("FAIL abort_latency got=%0d want=2", lat); end
    total++; if (quire !== (128'd3 << 47))    begin bad++; $display("FAIL abort_quire got=%h want=%h", quire, 128'd3 << 47); end
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_nar();
    test_len0();
    test_values();
    test_extremes();
    test_back_to_back();
    test_busy_start();
    test_rst_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
